// File: rtl/ysyx_23060180_mem_arbiter_pkg.sv
// Shared types and constants for the core memory-port arbiter and its front-end users.
package ysyx_23060180_mem_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam logic [3:0]  SZ_B     = 4'd1;
  localparam logic [3:0]  SZ_H     = 4'd2;
  localparam logic [3:0]  SZ_W     = 4'd4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060180_mem_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the memory model.
interface ysyx_23060180_mem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [3:0]        ls_wbit_en;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wbit_en;
  logic [31:0]       mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wbit_en, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en
  );

  // Requester/memory side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wbit_en, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en
  );

endinterface

// File: rtl/ysyx_23060180_mem_arbiter_rd_tag_pipe.sv
// Fixed-latency {valid, owner} shift register that routes each read response back to
// its issuer; cleared asynchronously so in-flight reads are dropped on reset.
module ysyx_23060180_rd_tag_pipe
  import ysyx_23060180_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rstn_in,
  input  logic   push_valid,
  input  owner_e push_owner,
  output logic   pop_valid,
  output owner_e pop_owner
);

  rd_tag_t stage [RD_LAT];

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: push_valid, owner: push_owner};
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_valid = stage[RD_LAT-1].valid;
  assign pop_owner = stage[RD_LAT-1].owner;

endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// Two-requester memory-port arbiter: LS priority with an IF starvation guard.
// Optional ARB_PERF_CNT_EN adds grant/stall performance counters.
module ysyx_23060180_mem_arbiter
  import ysyx_23060180_mem_pkg::*;
#(
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic                        clk,
  input  logic                        rstn_in,
  ysyx_23060180_mem_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_if_gnt,
  output logic [31:0]                 perf_ls_gnt,
  output logic [31:0]                 perf_if_stall
`endif
);

  localparam int             CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_gnt;
  logic             ls_gnt;
  logic             starved;
  logic             rd_accept;
  logic             pop_valid;
  owner_e           pop_owner;

  // Grants are suppressed while reset is asserted so every output reads 0.
  always_comb begin
    starved = bus.if_req && (starve_cnt == LIMIT);
    ls_gnt  = rstn_in && bus.ls_req && !starved;
    if_gnt  = rstn_in && bus.if_req && !ls_gnt;
  end

  always_comb begin
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_raddr   = '0;
    bus.mem_wdata   = '0;
    bus.mem_wbit_en = '0;
    if (if_gnt) begin
      bus.mem_rd    = 1'b1;
      bus.mem_raddr = bus.if_addr;
    end else if (ls_gnt) begin
      bus.mem_raddr = bus.ls_addr;
      if (bus.ls_we) begin
        bus.mem_wr      = 1'b1;
        bus.mem_wdata   = bus.ls_wdata;
        bus.mem_wbit_en = bus.ls_wbit_en;
      end else begin
        bus.mem_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign rd_accept = if_gnt || (ls_gnt && !bus.ls_we);

  ysyx_23060180_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rstn_in    (rstn_in),
    .push_valid (rd_accept),
    .push_owner (if_gnt ? OWN_IF : OWN_LS),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner)
  );

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = pop_valid && (pop_owner == OWN_IF);
  assign bus.ls_rvalid = pop_valid && (pop_owner == OWN_LS);
  assign bus.if_rdata  = rstn_in ? bus.mem_rdata : 32'd0;
  assign bus.ls_rdata  = rstn_in ? bus.mem_rdata : 32'd0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      perf_if_gnt   <= '0;
      perf_ls_gnt   <= '0;
      perf_if_stall <= '0;
    end else begin
      if (if_gnt)                 perf_if_gnt   <= perf_if_gnt + 32'd1;
      if (ls_gnt)                 perf_ls_gnt   <= perf_ls_gnt + 32'd1;
      if (bus.if_req && !if_gnt)  perf_if_stall <= perf_if_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ysyx_23060180_mem_arbiter.md
Name: ysyx_23060180_mem_arbiter

Overview:
- Arbitrates the single core memory port between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the CPU core front-end/LSU and the memory model.
- Fixed LS priority, with a starvation counter that forces an IF grant after a bounded wait.
- Tracks in-flight reads in a fixed-latency tag pipeline so each response is routed back to the requester that issued it.

Parameters:
- RD_LAT, 1, memory read latency in cycles from the mem_rd cycle to the mem_rdata-valid cycle; legal range 1..4.
- STARVE_LIMIT, 4, number of consecutive denied IF-request cycles after which IF wins; must be >= 1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  core clock
- rstn_in  in  1  reset
- if_req  in  1  IF read request
- if_addr  in  ADDR_W  IF read address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  32  IF read data
- ls_req  in  1  LS request
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  ADDR_W  LS address
- ls_wdata  in  32  LS write data
- ls_wbit_en  in  4  write size code (1 = byte, 2 = half, 4 = word); passed through unchanged
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  LS read data valid
- ls_rdata  out  32  LS read data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_raddr  out  ADDR_W  memory address (used for both reads and writes)
- mem_wdata  out  32  memory write data
- mem_wbit_en  out  4  write size code
- mem_rdata  in  32  memory read data, valid RD_LAT cycles after mem_rd

Behaviour:
- Reset:
  - Single clock clk; reset rstn_in is asynchronous, active-low.
  - During reset: all outputs 0, tag pipeline cleared, starve_cnt = 0.
- Handshake:
  - A request is accepted in the cycle where req && gnt.
  - Grants are combinational from the current cycle's requests and starve_cnt.
  - At most one grant per cycle. Back-to-back accepts on consecutive cycles are allowed.
  - Requesters hold req and payload stable until gnt.
- Grant rule:
  - Only one requester active: that requester is granted.
  - Both active and starve_cnt < STARVE_LIMIT: LS is granted.
  - Both active and starve_cnt == STARVE_LIMIT: IF is granted.
- starve_cnt:
  - Increments when if_req && !if_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 when if_gnt or !if_req.
- Memory drive (combinational from the granted requester):
  - IF granted: mem_rd = 1, mem_raddr = if_addr.
  - LS read granted: mem_rd = 1, mem_raddr = ls_addr.
  - LS write granted: mem_wr = 1, mem_raddr = ls_addr, mem_wdata = ls_wdata, mem_wbit_en = ls_wbit_en.
  - No grant: all mem_* outputs = 0.
- Writes complete in the grant cycle; they produce no rvalid and no tag-pipeline entry.
- Tag pipeline:
  - RD_LAT stages of {valid, owner}. Entry pushed on every accepted read, advanced every cycle.
  - Exit stage valid: pulse the owner's rvalid for exactly 1 cycle.
  - if_rdata and ls_rdata are both wired to mem_rdata; only rvalid is qualified by owner.
- Latency: with RD_LAT = 1, a read accepted at cycle N gives rvalid at N+1.
- Ordering: responses return in issue order. No reordering and no backpressure on responses; requesters must always sink rvalid.
- Reset mid-operation: in-flight reads are dropped and no rvalid is emitted after reset release.
- Simultaneous IF and LS write at saturation: IF wins; LS write waits with payload held.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds output ports perf_if_gnt (32), perf_ls_gnt (32) and perf_if_stall (32).
  - Each is a free-running wrapping counter of IF grants, LS grants, and cycles with if_req && !if_gnt respectively.
  - All reset to 0.
- Undefined: these ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Shared package ysyx_23060180_mem_pkg:
  - Owner enum: OWN_IF = 0, OWN_LS = 1.
  - Size-code constants: SZ_B = 1, SZ_H = 2, SZ_W = 4.
  - Default reset PC constant 32'h80000000, for front-end use.
- One sub-module: ysyx_23060180_rd_tag_pipe, an RD_LAT-deep {valid, owner} shift register with a clear-on-reset input.

Test Plan:
- IF only, if_addr = 32'h80000000, RD_LAT = 1, mem_rdata = 32'h00100093:
  - if_gnt at cycle N; mem_rd = 1, mem_raddr = 32'h80000000 at N.
  - if_rvalid = 1, if_rdata = 32'h00100093 at N+1; ls_rvalid = 0.
- Both requesting every cycle, STARVE_LIMIT = 4:
  - LS granted cycles 0–3, IF granted cycle 4, then LS again at cycle 5.
  - starve_cnt returns to 0 at cycle 5.
- LS write of 32'hDEADBEEF to 32'h80001000 with ls_wbit_en = 4:
  - mem_wr = 1 with matching address, data and size in the grant cycle.
  - No rvalid afterwards.
- RD_LAT = 3, alternating IF/LS reads on 4 consecutive cycles:
  - rvalid pulses arrive 3 cycles after each accept, in the same IF/LS/IF/LS order.
- Assert rstn_in low one cycle after an accepted read (RD_LAT = 2):
  - No rvalid ever appears for that read; all outputs are 0 during reset.
- With ARB_PERF_CNT_EN, run 10 IF-only accepted reads:
  - perf_if_gnt = 10, perf_ls_gnt = 0, perf_if_stall = 0.
